// File: rtl/trigger_clk_phase_ctrl_pkg.sv
// trigger_clk_phase_pkg
// Shared definitions for the MMCM phase-shift sequencer: the state encoding
// and the default psdone timeout (in usb_clk cycles).
// No ports.

package trigger_clk_phase_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOCKWAIT = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAITDONE = 3'd3,
        ST_DRAIN    = 3'd4
    } state_t;

endpackage

// File: rtl/trigger_clk_phase_ctrl_if.sv
// trigger_clk_phase_ctrl_if
// Request/status bundle between a phase-shift client (master) and the
// trigger_clk_phase_ctrl sequencer (slave), including the MMCM handshake.
// Signals:
//   I_start, I_step_count, I_step_dir  sequence request
//   I_abort, I_clear_error             control
//   I_locked, I_psdone                 MMCM status
//   O_psen, O_psincdec                 MMCM phase-shift controls
//   O_busy, O_done, O_error, O_phase   sequencer status

interface trigger_clk_phase_ctrl_if #(
    parameter int pSTEP_WIDTH = 16
) ();

    logic                      I_start;
    logic [pSTEP_WIDTH-1:0]    I_step_count;
    logic                      I_step_dir;
    logic                      I_abort;
    logic                      I_clear_error;
    logic                      I_locked;
    logic                      I_psdone;
    logic                      O_psen;
    logic                      O_psincdec;
    logic                      O_busy;
    logic                      O_done;
    logic                      O_error;
    logic signed [pSTEP_WIDTH:0] O_phase;

    modport master (
        output I_start, I_step_count, I_step_dir, I_abort, I_clear_error,
               I_locked, I_psdone,
        input  O_psen, O_psincdec, O_busy, O_done, O_error, O_phase
    );

    modport slave (
        input  I_start, I_step_count, I_step_dir, I_abort, I_clear_error,
               I_locked, I_psdone,
        output O_psen, O_psincdec, O_busy, O_done, O_error, O_phase
    );

endinterface

// File: rtl/trigger_clk_phase_ctrl.sv
// trigger_clk_phase_ctrl
// Steps an MMCM dynamic phase shift by a requested number of increments or
// decrements, one psen/psdone handshake at a time, and tracks the
// accumulated signed phase position.
// Ports:
//   usb_clk  sole clock (MMCM psclk domain)
//   reset    synchronous, active-high
//   bus      trigger_clk_phase_ctrl_if.slave (request, MMCM handshake, status)
// Build option: define PHASE_TIMEOUT_EN to abort with O_error when psdone
// does not arrive within pTIMEOUT cycles of entering WAITDONE or DRAIN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for an accepted I_start
// LOCKWAIT | sequence captured, waiting for the MMCM to be locked
// ISSUE    | O_psen high for this single cycle
// WAITDONE | step issued, waiting for I_psdone
// DRAIN    | aborted, waiting for the outstanding I_psdone

module trigger_clk_phase_ctrl
    import trigger_clk_phase_pkg::*;
#(
    parameter int pSTEP_WIDTH = 16,
    parameter int pTIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic usb_clk,
    input  logic reset,
    trigger_clk_phase_ctrl_if.slave bus
);

    localparam logic [pSTEP_WIDTH-1:0]    CNT_ONE = pSTEP_WIDTH'(1);
    localparam logic signed [pSTEP_WIDTH:0] PH_ONE = (pSTEP_WIDTH+1)'(1);

    if (pTIMEOUT < 1) begin : g_bad_timeout
        $error("pTIMEOUT must be at least 1");
    end

    state_t                      state;
    logic [pSTEP_WIDTH-1:0]      remaining;
    logic signed [pSTEP_WIDTH:0] phase;
    logic                        psen;
    logic                        psincdec;
    logic                        busy;
    logic                        done;
    logic                        error;
    logic                        locked_q;
    logic                        lock_lost;
    logic signed [pSTEP_WIDTH:0] phase_next;

`ifdef PHASE_TIMEOUT_EN
    localparam int               TW       = $clog2(pTIMEOUT + 1);
    localparam logic [TW-1:0]    TMR_LOAD = TW'(pTIMEOUT - 1);
    logic [TW-1:0]               tmr;
    logic                        tmr_expired;
    assign tmr_expired = (tmr == '0);
`endif

    // LOCKWAIT exists to wait for lock, so only a falling edge counts there;
    // every later state was entered with lock held, so a low level is a loss.
    assign lock_lost = (state == ST_LOCKWAIT) ? (locked_q & ~bus.I_locked)
                                              : ((state != ST_IDLE) & ~bus.I_locked);

    assign phase_next = psincdec ? (phase + PH_ONE) : (phase - PH_ONE);

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            phase     <= '0;
            psen      <= 1'b0;
            psincdec  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            locked_q  <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
            tmr       <= TMR_LOAD;
`endif
        end else begin
            locked_q <= bus.I_locked;
            done     <= 1'b0;
            psen     <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
            tmr      <= TMR_LOAD;
`endif
            // Any error set below is a later assignment, so set beats clear.
            if (bus.I_clear_error) begin
                error <= 1'b0;
            end

            if (lock_lost) begin
                error    <= 1'b1;
                state    <= ST_IDLE;
                busy     <= 1'b0;
                psincdec <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.I_start && !error) begin
                            if (bus.I_step_count == '0) begin
                                done <= 1'b1;
                            end else begin
                                remaining <= bus.I_step_count;
                                psincdec  <= bus.I_step_dir;
                                busy      <= 1'b1;
                                state     <= ST_LOCKWAIT;
                            end
                        end
                    end
                    ST_LOCKWAIT: begin
                        if (bus.I_abort) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            psincdec <= 1'b0;
                        end else if (bus.I_locked) begin
                            state <= ST_ISSUE;
                            psen  <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        state <= bus.I_abort ? ST_DRAIN : ST_WAITDONE;
                    end
                    ST_WAITDONE: begin
                        if (bus.I_psdone) begin
                            remaining <= remaining - CNT_ONE;
                            phase     <= phase_next;
                            if (bus.I_abort || remaining == CNT_ONE) begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                psincdec <= 1'b0;
                                done     <= ~bus.I_abort;
                            end else begin
                                state <= ST_ISSUE;
                                psen  <= 1'b1;
                            end
`ifdef PHASE_TIMEOUT_EN
                        end else if (tmr_expired) begin
                            error    <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            psincdec <= 1'b0;
`endif
                        end else if (bus.I_abort) begin
                            state <= ST_DRAIN;
                        end else begin
`ifdef PHASE_TIMEOUT_EN
                            tmr <= tmr - TW'(1);
`endif
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.I_psdone) begin
                            remaining <= remaining - CNT_ONE;
                            phase     <= phase_next;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            psincdec  <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
                        end else if (tmr_expired) begin
                            error    <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            psincdec <= 1'b0;
                        end else begin
                            tmr <= tmr - TW'(1);
`endif
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        psincdec <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.O_psen     = psen;
    assign bus.O_psincdec = psincdec;
    assign bus.O_busy     = busy;
    assign bus.O_done     = done;
    assign bus.O_error    = error;
    assign bus.O_phase    = phase;

endmodule

// File: tb/tb_trigger_clk_phase_ctrl.sv
// tb_trigger_clk_phase_ctrl
// Directed stimulus for trigger_clk_phase_ctrl. Expected MMCM pulses and
// end-of-sequence events are queued when a sequence is launched; a monitor
// pops and compares them whenever the DUT shows O_psen, O_done or a fall
// of O_busy. A responder answers each O_psen with I_psdone 3 cycles later.
// Define PHASE_TIMEOUT_EN to also exercise the psdone timeout (pTIMEOUT=10).

module tb_trigger_clk_phase_ctrl;

    localparam int W = 16;

    localparam int EV_PSEN  = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;
    localparam int EV_ERR   = 3;

    typedef struct {
        int kind;
        bit dir;
        int phase;
    } exp_t;

    logic usb_clk = 1'b0;
    logic reset   = 1'b1;

    trigger_clk_phase_ctrl_if #(.pSTEP_WIDTH(W)) bus_if ();

    trigger_clk_phase_ctrl #(.pSTEP_WIDTH(W), .pTIMEOUT(10)) dut (
        .usb_clk (usb_clk),
        .reset   (reset),
        .bus     (bus_if)
    );

    always #5 usb_clk = ~usb_clk;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    bit   auto_done = 1'b1;

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(int kind, bit dir, int phase);
        exp_t e;
        e.kind  = kind;
        e.dir   = dir;
        e.phase = phase;
        sb.push_back(e);
    endtask

    task automatic mon_event(int kind);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind) begin
            n_fail++;
            $display("FAIL event_kind: got %0d expected %0d at %0t", kind, e.kind, $time);
        end else if (kind == EV_PSEN && bus_if.O_psincdec != e.dir) begin
            n_fail++;
            $display("FAIL psincdec: got %0d expected %0d at %0t", bus_if.O_psincdec, e.dir, $time);
        end else if (kind != EV_PSEN && $signed(bus_if.O_phase) != e.phase) begin
            n_fail++;
            $display("FAIL end_phase: got %0d expected %0d at %0t",
                     $signed(bus_if.O_phase), e.phase, $time);
        end else if (kind == EV_DONE && bus_if.O_busy) begin
            n_fail++;
            $display("FAIL busy_at_done: got 1 expected 0 at %0t", $time);
        end
    endtask

    // Monitor
    initial begin
        bit busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge usb_clk);
            if (reset) begin
                busy_prev = 1'b0;
            end else begin
                if (bus_if.O_psen) mon_event(EV_PSEN);
                if (bus_if.O_done) mon_event(EV_DONE);
                else if (busy_prev && !bus_if.O_busy)
                    mon_event(bus_if.O_error ? EV_ERR : EV_ABORT);
                busy_prev = bus_if.O_busy;
            end
        end
    end

    // MMCM psdone responder
    initial begin
        bus_if.I_psdone = 1'b0;
        forever begin
            @(negedge usb_clk);
            if (bus_if.O_psen && auto_done) begin
                repeat (3) @(posedge usb_clk);
                #1 bus_if.I_psdone = 1'b1;
                @(posedge usb_clk);
                #1 bus_if.I_psdone = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge usb_clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_start(int cnt, bit dir);
        @(posedge usb_clk);
        #1;
        bus_if.I_start      = 1'b1;
        bus_if.I_step_count = W'(cnt);
        bus_if.I_step_dir   = dir;
        @(posedge usb_clk);
        #1;
        bus_if.I_start = 1'b0;
    endtask

    task automatic wait_psen(int nth, int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen < nth; i++) begin
            @(negedge usb_clk);
            if (bus_if.O_psen) seen++;
        end
        chk("wait_psen", seen, nth);
    endtask

    task automatic wait_idle(int budget);
        int i;
        i = 0;
        do begin
            @(negedge usb_clk);
            i++;
        end while (bus_if.O_busy && i < budget);
        chk("wait_idle", bus_if.O_busy, 0);
    endtask

    initial begin
        bus_if.I_start       = 1'b0;
        bus_if.I_step_count  = '0;
        bus_if.I_step_dir    = 1'b0;
        bus_if.I_abort       = 1'b0;
        bus_if.I_clear_error = 1'b0;
        bus_if.I_locked      = 1'b1;

        do_reset();
        @(negedge usb_clk);
        chk("rst_psen",     bus_if.O_psen, 0);
        chk("rst_psincdec", bus_if.O_psincdec, 0);
        chk("rst_busy",     bus_if.O_busy, 0);
        chk("rst_done",     bus_if.O_done, 0);
        chk("rst_error",    bus_if.O_error, 0);
        chk("rst_phase",    $signed(bus_if.O_phase), 0);

        // zero-step request
        expect_ev(EV_DONE, 1'b0, 0);
        do_start(0, 1'b1);
        @(negedge usb_clk);
        chk("zero_done_pulse", bus_if.O_done, 1);
        chk("zero_no_psen",    bus_if.O_psen, 0);
        repeat (4) @(negedge usb_clk);
        chk("zero_phase", $signed(bus_if.O_phase), 0);

        // 5 increments
        for (int i = 0; i < 5; i++) expect_ev(EV_PSEN, 1'b1, 0);
        expect_ev(EV_DONE, 1'b0, 5);
        do_start(5, 1'b1);
        @(negedge usb_clk);
        chk("psen_not_early", bus_if.O_psen, 0);
        @(negedge usb_clk);
        chk("psen_latency", bus_if.O_psen, 1);
        wait_idle(300);
        chk("inc_phase",     $signed(bus_if.O_phase), 5);
        chk("idle_psincdec", bus_if.O_psincdec, 0);

        // 3 decrements from +5
        for (int i = 0; i < 3; i++) expect_ev(EV_PSEN, 1'b0, 0);
        expect_ev(EV_DONE, 1'b0, 2);
        do_start(3, 1'b0);
        wait_idle(300);
        chk("dec_phase", $signed(bus_if.O_phase), 2);

        // abort after the second step is issued
        do_reset();
        @(negedge usb_clk);
        chk("rst_clears_phase", $signed(bus_if.O_phase), 0);
        expect_ev(EV_PSEN, 1'b1, 0);
        expect_ev(EV_PSEN, 1'b1, 0);
        expect_ev(EV_ABORT, 1'b0, 2);
        do_start(5, 1'b1);
        wait_psen(2, 100);
        @(posedge usb_clk);
        #1 bus_if.I_abort = 1'b1;
        @(posedge usb_clk);
        #1 bus_if.I_abort = 1'b0;
        @(negedge usb_clk);
        chk("busy_in_drain", bus_if.O_busy, 1);
        wait_idle(100);
        chk("abort_phase", $signed(bus_if.O_phase), 2);
        chk("abort_no_done", bus_if.O_done, 0);

        // lock loss while waiting for psdone
        auto_done = 1'b0;
        expect_ev(EV_PSEN, 1'b1, 0);
        expect_ev(EV_ERR, 1'b0, 2);
        do_start(4, 1'b1);
        wait_psen(1, 100);
        @(posedge usb_clk);
        #1 bus_if.I_locked = 1'b0;
        @(negedge usb_clk);
        @(negedge usb_clk);
        chk("lock_loss_error", bus_if.O_error, 1);
        chk("lock_loss_busy",  bus_if.O_busy, 0);
        bus_if.I_locked = 1'b1;
        auto_done = 1'b1;
        do_start(1, 1'b0);
        repeat (4) @(negedge usb_clk);
        chk("start_ignored_busy", bus_if.O_busy, 0);
        chk("error_sticky",       bus_if.O_error, 1);
        @(posedge usb_clk);
        #1 bus_if.I_clear_error = 1'b1;
        @(posedge usb_clk);
        #1 bus_if.I_clear_error = 1'b0;
        @(negedge usb_clk);
        chk("error_cleared",       bus_if.O_error, 0);
        chk("clear_keeps_phase",   $signed(bus_if.O_phase), 2);
        expect_ev(EV_PSEN, 1'b0, 0);
        expect_ev(EV_DONE, 1'b0, 1);
        do_start(1, 1'b0);
        wait_idle(100);
        chk("post_clear_phase", $signed(bus_if.O_phase), 1);

`ifdef PHASE_TIMEOUT_EN
        auto_done = 1'b0;
        expect_ev(EV_PSEN, 1'b1, 0);
        expect_ev(EV_ERR, 1'b0, 1);
        do_start(1, 1'b1);
        wait_psen(1, 100);
        repeat (10) @(negedge usb_clk);
        chk("timeout_not_early", bus_if.O_error, 0);
        @(negedge usb_clk);
        chk("timeout_error", bus_if.O_error, 1);
        auto_done = 1'b1;
        @(posedge usb_clk);
        #1 bus_if.I_clear_error = 1'b1;
        @(posedge usb_clk);
        #1 bus_if.I_clear_error = 1'b0;
`endif

        repeat (10) @(negedge usb_clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_clk_phase_ctrl.md
TRIGGER_CLK_PHASE_CTRL -- requirements
Module: trigger_clk_phase_ctrl

Interface
REQ-001 SHALL have parameter pSTEP_WIDTH, default 16, width of the requested step count.
REQ-002 SHALL have parameter pTIMEOUT, default 255, which is the maximum number of usb_clk cycles to wait for I_psdone.
REQ-003 SHALL use one clock and a synchronous, active-high reset; no other clock domains.
REQ-004 SHALL have usb_clk, input, 1: sole clock; MMCM psclk domain.
REQ-005 SHALL have reset, input, 1: synchronous, active-high.
REQ-006 SHALL have I_start, input, 1: single-cycle request to begin a phase-shift sequence.
REQ-007 SHALL have I_step_count, input, pSTEP_WIDTH: unsigned number of steps, sampled on an accepted I_start.
REQ-008 SHALL have I_step_dir, input, 1: 1 = increment, 0 = decrement; sampled on an accepted I_start.
REQ-009 SHALL have I_abort, input, 1: stop the sequence after any outstanding step completes.
REQ-010 SHALL have I_clear_error, input, 1: clears O_error.
REQ-011 SHALL have I_locked, input, 1: MMCM locked.
REQ-012 SHALL have I_psdone, input, 1: MMCM phase-shift done.
REQ-013 SHALL have O_psen, output, 1: MMCM phase-shift enable.
REQ-014 SHALL have O_psincdec, output, 1: MMCM phase-shift direction.
REQ-015 SHALL have O_busy, output, 1: a sequence is in progress.
REQ-016 SHALL have O_done, output, 1: one-cycle completion pulse.
REQ-017 SHALL have O_error, output, 1: sticky fault flag (timeout or lock loss).
REQ-018 SHALL have O_phase, output, pSTEP_WIDTH+1: signed, two's-complement accumulated phase position.

Function
REQ-019 SHALL implement the states IDLE, LOCKWAIT, ISSUE, WAITDONE and DRAIN.
REQ-020 SHALL accept I_start only in IDLE with O_error=0; otherwise I_start SHALL be ignored.
REQ-021 SHALL, on an accepted I_start with I_step_count=0, pulse O_done on the next cycle and never assert O_psen.
REQ-022 SHALL, on an accepted I_start with a nonzero count, capture the count and direction and move IDLE->LOCKWAIT.
REQ-023 SHALL move LOCKWAIT->ISSUE when I_locked=1; with I_locked steady high, O_psen SHALL first rise 2 cycles after I_start.
REQ-024 SHALL hold O_psen high for exactly one cycle in ISSUE, then move to WAITDONE.
REQ-025 SHALL never assert O_psen while a step's I_psdone is outstanding.
REQ-026 SHALL drive O_psincdec to the captured direction from LOCKWAIT until return to IDLE, and SHALL hold it at 0 in IDLE.
REQ-027 SHALL, on each I_psdone in WAITDONE, decrement the remaining count and add ±1 to O_phase (modulo 2^(pSTEP_WIDTH+1)).
REQ-028 SHALL, after that I_psdone, go to ISSUE if the remaining count is >0; otherwise go to IDLE and pulse O_done.
REQ-029 SHALL drive O_busy high in every state except IDLE, and O_busy SHALL fall in the same cycle that O_done pulses.
REQ-030 SHALL ignore I_psdone in IDLE, LOCKWAIT or ISSUE, with no count or phase change.
REQ-031 SHALL, on I_abort in LOCKWAIT, go to IDLE immediately without pulsing O_done.
REQ-032 SHALL, on I_abort in ISSUE or WAITDONE, go to DRAIN.
REQ-033 SHALL, in DRAIN, wait for I_psdone, count that step into O_phase, then go to IDLE without pulsing O_done.
REQ-034 SHALL, when I_abort and I_psdone arrive in the same WAITDONE cycle, count the step and go to IDLE.
REQ-035 SHALL, when I_locked falls in any non-IDLE state, set O_error and go to IDLE in the next cycle, with no O_done and no further O_psen.
REQ-036 SHALL clear O_error on I_clear_error; if a set condition occurs in the same cycle, set SHALL win.

Reset
REQ-037 SHALL, on reset, enter IDLE.
REQ-038 SHALL, on reset, drive O_psen, O_psincdec, O_busy, O_done and O_error to 0.
REQ-039 SHALL, on reset, set O_phase and the remaining count to 0.
REQ-040 SHALL take reset mid-sequence in the next cycle, abandoning any outstanding I_psdone.
REQ-041 SHALL clear O_phase only on reset; I_clear_error SHALL NOT affect it.

Configuration
REQ-042 SHALL, with PHASE_TIMEOUT_EN defined, count cycles in WAITDONE and DRAIN, restarting the count on each entry.
REQ-043 SHALL, with PHASE_TIMEOUT_EN defined, set O_error and go to IDLE once pTIMEOUT cycles pass without I_psdone.
REQ-044 SHALL, without PHASE_TIMEOUT_EN, wait indefinitely for I_psdone and contain no timeout counter logic.

Structure
REQ-045 SHALL place the state encoding and the default pTIMEOUT constant in shared package trigger_clk_phase_pkg.
REQ-046 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-047 SHALL verify that count=5, dir=1 with I_psdone 3 cycles after each O_psen gives exactly 5 O_psen pulses, O_phase=+5 and one O_done.
REQ-048 SHALL verify that count=3, dir=0 from O_phase=+5 ends with O_phase=+2 and O_psincdec=0 during all pulses.
REQ-049 SHALL verify that I_abort one cycle after the 2nd O_psen leaves O_busy high until that I_psdone, then O_phase=+2 with no O_done.
REQ-050 SHALL verify that I_locked falling in WAITDONE gives O_error=1, O_busy=0 next cycle, and that I_start is ignored until I_clear_error.
REQ-051 SHALL verify that with PHASE_TIMEOUT_EN and pTIMEOUT=10, withholding I_psdone sets O_error 10 cycles after entering WAITDONE.
REQ-052 SHALL verify that count=0 gives an O_done pulse 1 cycle after I_start, with no O_psen and O_phase unchanged.
